fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage for the 16-bit CPU. It owns the program counter and issues one instruction-memory request at a time using a valid/ready handshake.
- It drives the IF/ID pipeline register that decode consumes. The decoded source fields go straight to the register file read ports (SrcReg1/SrcReg2).
- It handles stall, branch redirect (flush) and halt.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_INC, 2, byte increment per 16-bit instruction.
- HALT_OP, 4'hF, opcode (instr[15:12]) that stops fetching.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  decode cannot accept; the IF/ID register holds.
- flush  input  1  branch taken; redirect to branch_target.
- branch_target  input  16  redirect PC.
- imem_req_valid  output  1  request valid.
- imem_req_addr  output  16  request address (equals pc_out).
- imem_req_ready  input  1  memory accepts the request.
- imem_rsp_valid  input  1  response data valid.
- imem_rsp_data  input  16  fetched instruction.
- ifid_valid  output  1  IF/ID register holds a valid instruction.
- ifid_instr  output  16  instruction.
- ifid_pc_plus2  output  16  fetch address + PC_INC.
- ifid_src1  output  4  ifid_instr[7:4], to register file SrcReg1.
- ifid_src2  output  4  ifid_instr[3:0], to register file SrcReg2.
- pc_out  output  16  current fetch PC.
- halted  output  1  fetch stopped on HALT_OP.
- perf_fetch_cnt  output  16  delivered-instruction count (see Optional Feature).

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=REQ, ifid_valid=0, ifid_instr=0, ifid_pc_plus2=0, halted=0, drop=0, buffer empty, perf_fetch_cnt=0. Reset overrides every other input.
- At most one request is outstanding at any time.
- State REQ:
  - imem_req_valid=1 and imem_req_addr=pc.
  - Request fires when imem_req_ready=1; go to WAIT.
- State WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid:
    - If drop=1: discard the response, clear drop, go to REQ.
    - Else if the IF/ID register can load (stall=0): load the IF/ID register, set pc=pc+PC_INC (modulo 2^16, so 16'hFFFE wraps to 16'h0000). Go to HALT if instr[15:12]==HALT_OP, otherwise go to REQ.
    - Else (stall=1): capture the response in the skid buffer and go to HOLD.
- State HOLD:
  - No request is issued.
  - When stall=0: load the IF/ID register from the buffer, advance pc, then go to HALT or REQ by the same opcode rule.
- State HALT:
  - halted=1 and no requests are issued.
  - Leaves HALT only on flush or rst.
- IF/ID register update:
  - Load: ifid_valid=1, ifid_instr=data, ifid_pc_plus2=fetch addr+PC_INC.
  - stall=1: all IF/ID outputs hold.
  - stall=0 with no new instruction this cycle: ifid_valid=0; other IF/ID fields hold.
- Latency: the response is visible on IF/ID outputs on the edge after the imem_rsp_valid cycle. A zero-wait memory gives one instruction every 2 cycles.
- Flush (priority over stall and over the response path):
  - pc=branch_target, ifid_valid=0, buffer cleared, halted=0.
  - If a request is outstanding (in WAIT, or REQ with ready=1 in the same cycle), set drop=1 and go to WAIT. Otherwise go to REQ.
  - Flush in WAIT with imem_rsp_valid in the same cycle: drop that response and go to REQ with drop=0.
- imem_rsp_valid outside WAIT is ignored; this covers late responses after reset.
- imem_req_addr must stay stable while imem_req_valid=1 and ready=0 (pc is only changed by flush).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: perf_fetch_cnt increments by 1 on each IF/ID load, saturates at 16'hFFFF, and is cleared by rst. It is not cleared by flush.
- Undefined: no counter logic; perf_fetch_cnt is tied to 16'h0000.

Test Plan:
- Reset, RESET_PC=0, memory ready=1 with a 1-cycle response of 16'h1123 → imem_req_addr=16'h0000 in the first cycle after rst falls. Then ifid_valid=1, ifid_instr=16'h1123, ifid_pc_plus2=16'h0002, ifid_src1=2, ifid_src2=3, pc_out=16'h0002.
- stall=1 for 3 cycles while a response of 16'h2456 arrives → HOLD; IF/ID unchanged and no new request. After stall falls: ifid_instr=16'h2456, then the next request is 16'h0004. No loss or duplication.
- flush with target 16'h0040 while in WAIT, response arriving 2 cycles later → response discarded and ifid_valid=0. Next imem_req_addr=16'h0040.
- Instruction 16'hF000 fetched at 16'h0006 → delivered to IF/ID, halted=1, imem_req_valid stays 0 for 10 cycles. Then flush to 16'h0010 → halted=0 and request to 16'h0010.
- rst asserted in WAIT, stale imem_rsp_valid one cycle after rst falls → all outputs at reset values and the stale response is ignored. First request is to RESET_PC.
- With FETCH_PERF_CNT_EN: 5 delivered instructions plus 1 dropped by flush → perf_fetch_cnt=5. Without the macro it stays 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and drives the IF/ID register.
// Optional delivered-instruction counter is enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] branch_target,
  output logic        imem_req_valid,
  output logic [15:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [15:0] imem_rsp_data,
  output logic        ifid_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic [3:0]  ifid_src1,
  output logic [3:0]  ifid_src2,
  output logic [15:0] pc_out,
  output logic        halted,
  output logic [15:0] perf_fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic        drop, drop_nxt;
  logic [15:0] buf_data, buf_nxt;
  logic        load;
  logic [15:0] load_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      buf_data <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      drop     <= drop_nxt;
      buf_data <= buf_nxt;
    end
  end

  // Flush wins over everything; drop marks a request already in flight whose answer must be thrown away.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    buf_nxt   = buf_data;
    load      = 1'b0;
    load_data = (state == S_HOLD) ? buf_data : imem_rsp_data;
    if (flush) begin
      pc_nxt  = branch_target;
      buf_nxt = '0;
      if (state == S_WAIT && imem_rsp_valid) begin
        state_nxt = S_REQ;
        drop_nxt  = 1'b0;
      end else if (state == S_WAIT || (state == S_REQ && imem_req_ready)) begin
        state_nxt = S_WAIT;
        drop_nxt  = 1'b1;
      end else begin
        state_nxt = S_REQ;
        drop_nxt  = 1'b0;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_ready) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop) begin
              drop_nxt  = 1'b0;
              state_nxt = S_REQ;
            end else if (!stall) begin
              load = 1'b1;
            end else begin
              buf_nxt   = imem_rsp_data;
              state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) load = 1'b1;
        end
        S_HALT: begin
          state_nxt = S_HALT;
        end
      endcase
      if (load) begin
        pc_nxt    = pc + PC_INC;
        state_nxt = (load_data[15:12] == HALT_OP) ? S_HALT : S_REQ;
      end
    end
  end

  // IF/ID register: holds under stall, bubbles when decode is free but nothing new arrived.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_valid    <= 1'b0;
      ifid_instr    <= '0;
      ifid_pc_plus2 <= '0;
    end else if (flush) begin
      ifid_valid <= 1'b0;
    end else if (load) begin
      ifid_valid    <= 1'b1;
      ifid_instr    <= load_data;
      ifid_pc_plus2 <= pc + PC_INC;
    end else if (!stall) begin
      ifid_valid <= 1'b0;
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;
  assign pc_out         = pc;
  assign halted         = (state == S_HALT);
  assign ifid_src1      = ifid_instr[7:4];
  assign ifid_src2      = ifid_instr[3:0];

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt <= '0;
    end else if (load && perf_cnt != 16'hFFFF) begin
      perf_cnt <= perf_cnt + 16'd1;
    end
  end

  assign perf_fetch_cnt = perf_cnt;
`else
  assign perf_fetch_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against an
// address-sequence reference model with a latency-randomizing instruction memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [15:0] branch_target;
  logic        imem_req_valid;
  logic [15:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic [3:0]  ifid_src1;
  logic [3:0]  ifid_src2;
  logic [15:0] pc_out;
  logic        halted;
  logic [15:0] perf_fetch_cnt;

  int checks = 0;
  int failures = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc_plus2  (ifid_pc_plus2),
    .ifid_src1      (ifid_src1),
    .ifid_src2      (ifid_src2),
    .pc_out         (pc_out),
    .halted         (halted),
    .perf_fetch_cnt (perf_fetch_cnt)
  );

  always #5 clk = ~clk;

  // Distinct word per address, so a wrongly delivered stale response cannot look correct.
  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    return (addr * 16'h9E37) ^ 16'hA5C3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    tick(); tick();
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc_plus2, pc_out, halted} !== {1'b0, 16'h0, 16'h0, 16'h0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_state got v=%0b i=%h p2=%h pc=%h h=%0b exp all zero", ifid_valid, ifid_instr, ifid_pc_plus2, pc_out, halted);
    end
    checks++;
    if (perf_fetch_cnt !== 16'h0) begin
      failures++; $display("[TB] FAIL reset_perf got=%h exp=0000", perf_fetch_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    imem_req_ready = 1'b1;
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 16'h0000}) begin
      failures++; $display("[TB] FAIL first_req got v=%0b a=%h exp v=1 a=0000", imem_req_valid, imem_req_addr);
    end
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 16'h1123;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL wait_no_req got=%0b exp=0", imem_req_valid);
    end
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc_plus2, ifid_src1, ifid_src2, pc_out} !== {1'b1, 16'h1123, 16'h0002, 4'h2, 4'h3, 16'h0002}) begin
      failures++;
      $display("[TB] FAIL first_fetch got v=%0b i=%h p2=%h s1=%h s2=%h pc=%h exp v=1 i=1123 p2=0002 s1=2 s2=3 pc=0002",
               ifid_valid, ifid_instr, ifid_pc_plus2, ifid_src1, ifid_src2, pc_out);
    end
  endtask

  task automatic test_stall();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; stall = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 16'h2456;
    for (int i = 0; i < 3; i++) begin
      tick();
      imem_rsp_valid = 1'b0;
      checks++;
      if ({imem_req_valid, ifid_instr, ifid_pc_plus2} !== {1'b0, 16'h1123, 16'h0002}) begin
        failures++;
        $display("[TB] FAIL stall_hold cyc=%0d got rv=%0b i=%h p2=%h exp rv=0 i=1123 p2=0002", i, imem_req_valid, ifid_instr, ifid_pc_plus2);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc_plus2, imem_req_valid, imem_req_addr} !== {1'b1, 16'h2456, 16'h0004, 1'b1, 16'h0004}) begin
      failures++;
      $display("[TB] FAIL stall_release got v=%0b i=%h p2=%h rv=%0b ra=%h exp v=1 i=2456 p2=0004 rv=1 ra=0004",
               ifid_valid, ifid_instr, ifid_pc_plus2, imem_req_valid, imem_req_addr);
    end
    tick();
    checks++;
    if (ifid_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL stall_no_dup got=%0b exp=0", ifid_valid);
    end
  endtask

  task automatic test_flush();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; flush = 1'b1; branch_target = 16'h0040;
    tick();
    flush = 1'b0;
    checks++;
    if ({ifid_valid, pc_out, imem_req_valid} !== {1'b0, 16'h0040, 1'b0}) begin
      failures++; $display("[TB] FAIL flush_wait got v=%0b pc=%h rv=%0b exp v=0 pc=0040 rv=0", ifid_valid, pc_out, imem_req_valid);
    end
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 16'h1777;
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if ({ifid_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 16'h0040}) begin
      failures++; $display("[TB] FAIL flush_drop got v=%0b rv=%0b ra=%h exp v=0 rv=1 ra=0040", ifid_valid, imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 16'h3001;
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc_plus2} !== {1'b1, 16'h3001, 16'h0042}) begin
      failures++; $display("[TB] FAIL flush_refetch got v=%0b i=%h p2=%h exp v=1 i=3001 p2=0042", ifid_valid, ifid_instr, ifid_pc_plus2);
    end
  endtask

  task automatic test_halt();
    flush = 1'b1; branch_target = 16'h0006;
    tick();
    flush = 1'b0;
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 16'h0006}) begin
      failures++; $display("[TB] FAIL halt_redirect got rv=%0b ra=%h exp rv=1 ra=0006", imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 16'hF000;
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc_plus2, halted, imem_req_valid} !== {1'b1, 16'hF000, 16'h0008, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL halt_enter got v=%0b i=%h p2=%h h=%0b rv=%0b exp v=1 i=F000 p2=0008 h=1 rv=0", ifid_valid, ifid_instr, ifid_pc_plus2, halted, imem_req_valid);
    end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({halted, imem_req_valid} !== 2'b10) begin
        failures++; $display("[TB] FAIL halt_idle cyc=%0d got h=%0b rv=%0b exp h=1 rv=0", i, halted, imem_req_valid);
      end
    end
    imem_req_ready = 1'b0; flush = 1'b1; branch_target = 16'h0010;
    tick();
    flush = 1'b0;
    checks++;
    if ({halted, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 16'h0010}) begin
      failures++; $display("[TB] FAIL halt_exit got h=%0b rv=%0b ra=%h exp h=0 rv=1 ra=0010", halted, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_reset_in_wait();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 16'h1999;
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc_plus2, pc_out, halted, imem_req_valid} !== {1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL rst_wait got v=%0b i=%h p2=%h pc=%h h=%0b rv=%0b exp v=0 i=0 p2=0 pc=0 h=0 rv=1", ifid_valid, ifid_instr, ifid_pc_plus2, pc_out, halted, imem_req_valid);
    end
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if ({ifid_valid, ifid_instr, imem_req_valid, imem_req_addr, pc_out} !== {1'b0, 16'h0, 1'b1, 16'h0000, 16'h0000}) begin
      failures++;
      $display("[TB] FAIL rst_stale_rsp got v=%0b i=%h rv=%0b ra=%h pc=%h exp v=0 i=0 rv=1 ra=0000 pc=0000", ifid_valid, ifid_instr, imem_req_valid, imem_req_addr, pc_out);
    end
  endtask

  task automatic test_perf_counter();
    logic [15:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 16'h1000 + 16'(i);
      tick();
      imem_rsp_valid = 1'b0;
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; flush = 1'b1; branch_target = 16'h0020;
    tick();
    flush = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 16'h1005;
    tick();
    imem_rsp_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    exp_cnt = 16'd5;
`else
    exp_cnt = 16'd0;
`endif
    checks++;
    if ({ifid_valid, perf_fetch_cnt} !== {1'b0, exp_cnt}) begin
      failures++; $display("[TB] FAIL perf_count got v=%0b cnt=%0d exp v=0 cnt=%0d", ifid_valid, perf_fetch_cnt, exp_cnt);
    end
  endtask

  // Reference: instructions must arrive in address order from the last redirect target,
  // each carrying the memory word of its address; the PC always names the next address owed.
  task automatic test_random();
    logic        pending;
    logic [15:0] pend_addr;
    int          pend_cnt;
    logic        fire;
    logic [15:0] fire_addr;
    logic [15:0] m_pc, m_instr, m_pc2, m_perf, exp_perf;
    logic        m_valid, m_halt;
    int          delivered;
    do_reset();
    pending = 1'b0; pend_addr = '0; pend_cnt = 0;
    m_pc = 16'h0000; m_instr = '0; m_pc2 = '0; m_perf = '0; m_valid = 1'b0; m_halt = 1'b0;
    delivered = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      stall          = ($urandom_range(0, 3) == 0);
      flush          = ($urandom_range(0, 29) == 0);
      branch_target  = ($urandom_range(0, 3) == 0) ? 16'hFFFA : (16'($urandom) & 16'hFFFE);
      imem_req_ready = ($urandom_range(0, 4) < 3);
      imem_rsp_valid = pending && (pend_cnt == 0);
      imem_rsp_data  = imem_rsp_valid ? mem_word(pend_addr) : 16'($urandom);
      #1;
      fire      = imem_req_valid && imem_req_ready;
      fire_addr = imem_req_addr;
      if (imem_req_valid) begin
        checks++;
        if (imem_req_addr !== m_pc) begin
          failures++; $display("[TB] FAIL rnd_req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_pc);
        end
      end
      if (fire && pending) begin
        checks++; failures++;
        $display("[TB] FAIL rnd_two_outstanding cyc=%0d got=2 exp=1", cyc);
      end
      tick();
      if (imem_rsp_valid) pending = 1'b0;
      else if (pending) pend_cnt--;
      if (fire) begin
        pending = 1'b1; pend_addr = fire_addr; pend_cnt = $urandom_range(0, 2);
      end
      if (flush) begin
        m_pc = branch_target; m_valid = 1'b0; m_halt = 1'b0;
      end else if (!stall) begin
        if (ifid_valid) begin
          if (m_halt) begin
            checks++; failures++;
            $display("[TB] FAIL rnd_fetch_while_halted cyc=%0d got=1 exp=0", cyc);
          end
          m_instr = mem_word(m_pc);
          m_pc2   = m_pc + 16'd2;
          m_pc    = m_pc + 16'd2;
          m_valid = 1'b1;
          m_halt  = (m_instr[15:12] == 4'hF);
          if (m_perf != 16'hFFFF) m_perf = m_perf + 16'd1;
          delivered++;
        end else begin
          m_valid = 1'b0;
        end
      end
`ifdef FETCH_PERF_CNT_EN
      exp_perf = m_perf;
`else
      exp_perf = 16'h0000;
`endif
      checks++;
      if ({ifid_valid, ifid_instr, ifid_pc_plus2, ifid_src1, ifid_src2} !== {m_valid, m_instr, m_pc2, m_instr[7:4], m_instr[3:0]}) begin
        failures++;
        $display("[TB] FAIL rnd_ifid cyc=%0d got v=%0b i=%h p2=%h s1=%h s2=%h exp v=%0b i=%h p2=%h",
                 cyc, ifid_valid, ifid_instr, ifid_pc_plus2, ifid_src1, ifid_src2, m_valid, m_instr, m_pc2);
      end
      checks++;
      if ({pc_out, halted, perf_fetch_cnt} !== {m_pc, m_halt, exp_perf}) begin
        failures++;
        $display("[TB] FAIL rnd_state cyc=%0d got pc=%h h=%0b cnt=%0d exp pc=%h h=%0b cnt=%0d", cyc, pc_out, halted, perf_fetch_cnt, m_pc, m_halt, exp_perf);
      end
      if (m_halt) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin
          failures++; $display("[TB] FAIL rnd_halt_req cyc=%0d got=%0b exp=0", cyc, imem_req_valid);
        end
      end
    end
    checks++;
    if (delivered < 150) begin
      failures++; $display("[TB] FAIL rnd_progress got=%0d exp>=150", delivered);
    end
    stall = 1'b0; flush = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_flush();
    test_halt();
    test_reset_in_wait();
    test_perf_counter();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
